// File: rtl/xlr8_dbg_mailbox.sv
`timescale 1ns/1ps
// xlr8_dbg_mailbox
//   Debug mailbox on the AVR I/O bus. Software writes bytes into a TX FIFO
//   that drains over a valid/ready stream. The host fills an RX FIFO that
//   software reads. The END register latches a finish code and reports it
//   only after the TX FIFO has drained.
// Ports:
//   clk, rstn, clken            clock, async active-low reset, block enable
//   adr, dbus_in, iore, iowe    I/O bus request
//   dbus_out, io_out_en         I/O bus read data and its qualifier
//   tx_data/tx_valid/tx_ready   TX stream out
//   rx_data/rx_valid/rx_ready   RX stream in
//   ckpt_valid, ckpt_code       checkpoint pulse and last checkpoint value
//   end_valid, end_code, end_fail  end-of-test status
module xlr8_dbg_mailbox #(
   parameter int         TX_DEPTH = 16,
   parameter int         RX_DEPTH = 4,
   parameter logic [5:0] TXD_ADR  = 6'h2B,
   parameter logic [5:0] RXD_ADR  = 6'h2C,
   parameter logic [5:0] STAT_ADR = 6'h2D,
   parameter logic [5:0] END_ADR  = 6'h2E
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       clken,
   input  logic [5:0] adr,
   input  logic [7:0] dbus_in,
   input  logic       iore,
   input  logic       iowe,
   output logic [7:0] dbus_out,
   output logic       io_out_en,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       ckpt_valid,
   output logic [6:0] ckpt_code,
   output logic       end_valid,
   output logic [6:0] end_code,
   output logic       end_fail
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

   state_t state, state_nxt;

   // Bus decode; nothing takes effect while the block is disabled.
   logic tx_wr, rx_rd, stat_wr, end_wr;
   assign tx_wr   = clken & iowe & (adr == TXD_ADR);
   assign stat_wr = clken & iowe & (adr == STAT_ADR);
   assign end_wr  = clken & iowe & (adr == END_ADR);
   assign rx_rd   = clken & iore & (adr == RXD_ADR);

   // ---------------- TX FIFO ----------------
   // Pointers carry an extra wrap bit so all TX_DEPTH entries are usable.
   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wp, tx_rp, tx_cnt, tx_cnt_nxt;
   logic         tx_full, tx_empty, tx_push, tx_pop;

   assign tx_cnt   = tx_wp - tx_rp;
   assign tx_full  = (tx_cnt == (TAW+1)'(TX_DEPTH));
   assign tx_empty = (tx_wp == tx_rp);
   assign tx_valid = ~tx_empty & clken;
   assign tx_pop   = tx_valid & tx_ready;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign tx_push  = tx_wr & (~tx_full | tx_pop);
   assign tx_data  = tx_valid ? tx_mem[tx_rp[TAW-1:0]] : 8'h00;
   assign tx_cnt_nxt = tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= dbus_in;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wp, rx_rp;
   logic         rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0]   rx_head;

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp - rx_rp) == (RAW+1)'(RX_DEPTH);
   assign rx_ready = ~rx_full & clken;
   assign rx_push  = rx_valid & rx_ready;
   assign rx_pop   = rx_rd & ~rx_empty;
   assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[RAW-1:0]];

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   // ---------------- sticky flags, checkpoint, end code ----------------
   logic tx_ovf, rx_unf;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_ovf     <= 1'b0;
         rx_unf     <= 1'b0;
         ckpt_valid <= 1'b0;
         ckpt_code  <= '0;
         end_code   <= '0;
      end else if (clken) begin
         if (tx_wr & tx_full & ~tx_pop)    tx_ovf <= 1'b1;
         else if (stat_wr & dbus_in[3])    tx_ovf <= 1'b0;
         if (rx_rd & rx_empty)             rx_unf <= 1'b1;
         else if (stat_wr & dbus_in[4])    rx_unf <= 1'b0;
         ckpt_valid <= end_wr & ~dbus_in[7];
         if (end_wr & ~dbus_in[7])         ckpt_code <= dbus_in[6:0];
         // Only the first finish code is kept.
         if (end_wr & dbus_in[7] & (state == RUN)) end_code <= dbus_in[6:0];
      end
   end

   // ---------------- end-of-test FSM ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (end_wr & dbus_in[7]) state_nxt = DRAIN;
         // Look at the post-edge count so the final pop itself completes
         // the drain; fresh TX writes keep us here.
         DRAIN:   if (clken && tx_cnt_nxt == '0) state_nxt = DONE;
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      end_valid = (state == DONE);
      end_fail  = (state == DONE) & (|end_code);
   end

   // ---------------- read path ----------------
   logic [7:0] stat;
   assign stat = {1'b0, state, rx_unf, tx_ovf, ~rx_empty, tx_empty, tx_full};
   assign io_out_en = iore & clken & ((adr == RXD_ADR) | (adr == STAT_ADR));

   always_comb begin
      dbus_out = 8'h00;
      if (io_out_en) dbus_out = (adr == RXD_ADR) ? rx_head : stat;
   end

endmodule

// File: tb/tb_xlr8_dbg_mailbox.sv
`timescale 1ns/1ps
module tb_xlr8_dbg_mailbox;
   localparam logic [5:0] TXD = 6'h2B, RXD = 6'h2C, STA = 6'h2D, ENDA = 6'h2E;

   logic       clk = 1'b0;
   logic       rstn, clken, iore, iowe, tx_ready, rx_valid;
   logic [5:0] adr;
   logic [7:0] dbus_in, rx_data;
   logic [7:0] dbus_out, tx_data;
   logic       io_out_en, tx_valid, rx_ready, ckpt_valid, end_valid, end_fail;
   logic [6:0] ckpt_code, end_code;

   int checks = 0, failures = 0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];

   always #5 clk = ~clk;

   xlr8_dbg_mailbox dut (
      .clk(clk), .rstn(rstn), .clken(clken), .adr(adr), .dbus_in(dbus_in),
      .iore(iore), .iowe(iowe), .dbus_out(dbus_out), .io_out_en(io_out_en),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .ckpt_valid(ckpt_valid), .ckpt_code(ckpt_code),
      .end_valid(end_valid), .end_code(end_code), .end_fail(end_fail)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // TX scoreboard: every handshake must deliver the next expected byte.
   always @(negedge clk) begin
      if (rstn && tx_valid && tx_ready) begin
         if (txq.size() == 0) chk("tx_extra", 32'd1, 32'd0);
         else                 chk("tx_data", tx_data, txq.pop_front());
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
      adr = a; dbus_in = d; iowe = 1'b1;
      step();
      iowe = 1'b0;
   endtask

   task automatic io_rd(input logic [5:0] a, output logic [7:0] d, output logic en);
      adr = a; iore = 1'b1;
      #2 d = dbus_out; en = io_out_en;
      step();
      iore = 1'b0;
   endtask

   task automatic stat_is(input string tag, input logic [7:0] exp);
      logic [7:0] d; logic en;
      io_rd(STA, d, en);
      chk(tag, d, exp);
   endtask

   task automatic tx_put(input logic [7:0] b, input bit accepted);
      if (accepted) txq.push_back(b);
      io_wr(TXD, b);
   endtask

   task automatic rst_checks(input string tag);
      chk({tag, "_txv"}, tx_valid, 0);
      chk({tag, "_txd"}, tx_data, 0);
      chk({tag, "_rxr"}, rx_ready, 1);
      chk({tag, "_endv"}, end_valid, 0);
      chk({tag, "_endc"}, end_code, 0);
      chk({tag, "_endf"}, end_fail, 0);
      chk({tag, "_ckv"}, ckpt_valid, 0);
      chk({tag, "_ckc"}, ckpt_code, 0);
      chk({tag, "_oen"}, io_out_en, 0);
      chk({tag, "_dbo"}, dbus_out, 0);
   endtask

   task automatic do_reset(input string tag);
      rstn = 1'b0;
      #2 rst_checks(tag);
      txq.delete();
      step();
      rstn = 1'b1;
      step();
   endtask

   initial begin
      logic [7:0] d; logic en;
      logic [7:0] rxb [5];
      rxb = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03};
      clken = 1'b1; iore = 0; iowe = 0; adr = '0; dbus_in = '0;
      tx_ready = 0; rx_valid = 0; rx_data = '0;

      // Reset state
      do_reset("rst");
      stat_is("rst_stat", 8'h02);

      // "Hi" with consumer ready
      tx_ready = 1'b1;
      tx_put(8'h48, 1);
      chk("tx_lat", tx_valid, 1);
      tx_put(8'h69, 1);
      step();
      stat_is("hi_stat", 8'h02);

      // Overflow: 17 writes, consumer stalled
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) tx_put(8'h10 + 8'(i), i < 16);
      stat_is("ovf_stat", 8'h09);
      io_wr(STA, 8'h08);
      stat_is("ovf_clr", 8'h01);
      // write into a full FIFO while the head leaves
      tx_ready = 1'b1;
      tx_put(8'hEE, 1);
      tx_ready = 1'b0;
      stat_is("full_pop", 8'h01);
      tx_ready = 1'b1;
      for (int i = 0; i < 40 && txq.size() != 0; i++) step();
      chk("tx_drain_to", txq.size(), 0);
      stat_is("drained", 8'h02);

      // RX path
      for (int i = 0; i < 5; i++) begin
         rx_data = rxb[i]; rx_valid = 1'b1;
         #2 chk("rx_ready", rx_ready, (i < 4) ? 1 : 0);
         if (rx_ready) rxq.push_back(rxb[i]);
         step();
      end
      rx_valid = 1'b0;
      stat_is("rx_stat", 8'h06);
      for (int i = 0; i < 4; i++) begin
         io_rd(RXD, d, en);
         chk("rx_oen", en, 1);
         if (rxq.size() == 0) chk("rx_underq", 1, 0);
         else chk("rx_data", d, rxq.pop_front());
      end
      io_rd(RXD, d, en);
      chk("rx_unf_data", d, 8'h00);
      stat_is("rx_unf_stat", 8'h12);
      io_wr(STA, 8'h10);
      stat_is("rx_unf_clr", 8'h02);

      // End-of-test with bytes pending
      tx_ready = 1'b0;
      tx_put(8'h41, 1); tx_put(8'h42, 1); tx_put(8'h43, 1);
      io_wr(ENDA, 8'h83);
      stat_is("drain_stat", 8'h20);
      chk("drain_endv", end_valid, 0);
      tx_ready = 1'b1;
      step(); step();
      chk("drain_early", end_valid, 0);
      step();
      chk("done_endv", end_valid, 1);
      chk("done_code", end_code, 7'd3);
      chk("done_fail", end_fail, 1);
      io_wr(ENDA, 8'h80);
      chk("first_wins", end_code, 7'd3);
      stat_is("done_stat", 8'h42);

      // Checkpoint, then clean finish
      do_reset("rst2");
      io_wr(ENDA, 8'h05);
      chk("ckpt_v", ckpt_valid, 1);
      chk("ckpt_c", ckpt_code, 7'd5);
      step();
      chk("ckpt_pulse", ckpt_valid, 0);
      stat_is("ckpt_run", 8'h02);
      io_wr(ENDA, 8'h80);
      step();
      chk("pass_endv", end_valid, 1);
      chk("pass_fail", end_fail, 0);

      // Block disabled
      do_reset("rst3");
      clken = 1'b0; adr = STA; iore = 1'b1;
      #2 chk("dis_oen", io_out_en, 0);
      chk("dis_txv", tx_valid, 0);
      chk("dis_rxr", rx_ready, 0);
      iore = 1'b0;
      io_wr(TXD, 8'h77);
      clken = 1'b1;
      stat_is("dis_stat", 8'h02);

      // Reset in the middle of DRAIN
      tx_ready = 1'b0;
      tx_put(8'h31, 1); tx_put(8'h32, 1);
      io_wr(ENDA, 8'h81);
      stat_is("mid_drain", 8'h20);
      do_reset("rst4");
      stat_is("post_rst", 8'h02);

      chk("txq_empty", txq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
